// File: rtl/mem_op_sequencer_pkg.sv
// Shared types and sizes for the block-command memory sequencer.
// Latency: n/a (types only).  Backpressure: n/a.
package mem_seq_pkg;

    localparam int MEM_AW = 4;
    localparam int MEM_DW = 8;
    localparam int MEM_CW = MEM_AW + 1;

    typedef enum logic [1:0] {
        OP_FILL = 2'b00,
        OP_COPY = 2'b01,
        OP_SUM  = 2'b10,
        OP_RSVD = 2'b11
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/mem_op_sequencer_if.sv
// Command/status bundle (requester <-> sequencer) and memory port bundle (sequencer <-> memory).
// Latency: wires only.  Backpressure: cmd_valid/cmd_ready handshake on the command bundle.
interface mem_cmd_if
    import mem_seq_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW,
    parameter int CW = AW + 1
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_src;
    logic [AW-1:0] cmd_dst;
    logic [CW-1:0] cmd_count;
    logic [DW-1:0] cmd_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] result;
    logic          ovf;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_count, cmd_data,
        input  cmd_ready, busy, done, err, result, ovf
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_count, cmd_data,
        output cmd_ready, busy, done, err, result, ovf
    );
endinterface

interface mem_port_if
    import mem_seq_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
);
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr1;
    logic [AW-1:0] mem_raddr2;
    logic [DW-1:0] mem_rdata1;
    logic [DW-1:0] mem_rdata2;

    modport master (
        output mem_we, mem_waddr, mem_wdata, mem_raddr1, mem_raddr2,
        input  mem_rdata1, mem_rdata2
    );
    modport slave (
        input  mem_we, mem_waddr, mem_wdata, mem_raddr1, mem_raddr2,
        output mem_rdata1, mem_rdata2
    );
endinterface

// File: rtl/mem_op_sequencer_accum.sv
// SUM accumulator: wraps with sticky carry flag, or saturates when MEMSEQ_SUM_SAT_EN is defined.
// Latency: 1 cycle per add.  Backpressure: none, adds whenever i_add is high.
module seq_accum
    import mem_seq_pkg::*;
#(
    parameter int DW = MEM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_add,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_b_en,
    output logic [DW-1:0] o_sum,
    output logic          o_ovf
);
    logic [DW-1:0] r_acc;
    logic          r_ovf;
    logic [DW+1:0] w_total;
    logic          w_carry;
    logic [DW-1:0] w_next;

    always_comb begin
        w_total = {2'b00, r_acc} + {2'b00, i_a} + (i_b_en ? {2'b00, i_b} : '0);
        w_carry = |w_total[DW+1:DW];
`ifdef MEMSEQ_SUM_SAT_EN
        // A saturated accumulator re-saturates on any further add, so it stays pinned.
        w_next  = w_carry ? '1 : w_total[DW-1:0];
`else
        w_next  = w_total[DW-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_add) begin
            r_acc <= w_next;
            r_ovf <= r_ovf | w_carry;
        end
    end

    assign o_sum = r_acc;
    assign o_ovf = r_ovf;
endmodule

// File: rtl/mem_op_sequencer.sv
// Block-command sequencer (FILL/COPY/SUM) driving a 2R1W register-file memory; SUM saturation via MEMSEQ_SUM_SAT_EN.
// Latency: done pulses 1+run cycles after accept (run = count, or ceil(count/2) for SUM).  Backpressure: cmd_ready only in IDLE.
module mem_op_sequencer
    import mem_seq_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW,
    parameter int CW = AW + 1
) (
    input  logic        clk,
    input  logic        reset,
    mem_cmd_if.slave    cmd,
    mem_port_if.master  mem
);
    localparam logic [CW:0] ONE_X = (CW+1)'(1);
    localparam logic [CW:0] TWO_X = (CW+1)'(2);

    seq_state_t    r_state, w_next_state;
    mem_op_t       r_op;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_data;
    logic [CW-1:0] r_idx;
    logic          r_err;

    logic          w_accept;
    logic          w_last;
    logic          w_add;
    logic          w_b_en;
    logic [CW:0]   w_idx_x;
    logic [CW:0]   w_cnt_x;
    logic [AW-1:0] w_rd1;
    logic [AW-1:0] w_rd2;
    logic [AW-1:0] w_wa;
    mem_op_t       w_cmd_op;
    logic [DW-1:0] w_sum;
    logic          w_ovf;

    assign w_cmd_op = mem_op_t'(cmd.cmd_op);
    assign w_accept = (r_state == S_IDLE) && cmd.cmd_valid;

    // Address arithmetic truncates to AW bits so block ranges wrap around the top of memory.
    assign w_idx_x = {1'b0, r_idx};
    assign w_cnt_x = {1'b0, r_cnt};
    assign w_rd1   = r_src + r_idx[AW-1:0];
    assign w_rd2   = w_rd1 + AW'(1);
    assign w_wa    = r_dst + r_idx[AW-1:0];
    assign w_b_en  = (w_idx_x + ONE_X) < w_cnt_x;
    assign w_last  = (r_op == OP_SUM) ? ((w_idx_x + TWO_X) >= w_cnt_x)
                                      : ((w_idx_x + ONE_X) >= w_cnt_x);

    always_comb begin
        w_next_state   = r_state;
        w_add          = 1'b0;
        cmd.cmd_ready  = 1'b0;
        cmd.busy       = (r_state != S_IDLE);
        cmd.done       = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_waddr  = '0;
        mem.mem_wdata  = '0;
        mem.mem_raddr1 = '0;
        mem.mem_raddr2 = '0;

        case (r_state)
            S_IDLE: begin
                cmd.cmd_ready = 1'b1;
                if (w_accept) begin
                    if ((cmd.cmd_count == '0) || (w_cmd_op == OP_RSVD))
                        w_next_state = S_DONE;
                    else
                        w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                case (r_op)
                    OP_FILL: begin
                        mem.mem_we    = 1'b1;
                        mem.mem_waddr = w_wa;
                        mem.mem_wdata = r_data;
                    end
                    OP_COPY: begin
                        mem.mem_raddr1 = w_rd1;
                        mem.mem_we     = 1'b1;
                        mem.mem_waddr  = w_wa;
                        mem.mem_wdata  = mem.mem_rdata1;
                    end
                    OP_SUM: begin
                        mem.mem_raddr1 = w_rd1;
                        mem.mem_raddr2 = w_rd2;
                        w_add          = 1'b1;
                    end
                    default: ;
                endcase
                if (w_last)
                    w_next_state = S_DONE;
            end
            S_DONE: begin
                cmd.done     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase

        // The write in flight when reset arrives must not land in memory.
        if (reset)
            mem.mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_FILL;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op   <= w_cmd_op;
                r_src  <= cmd.cmd_src;
                r_dst  <= cmd.cmd_dst;
                r_cnt  <= cmd.cmd_count;
                r_data <= cmd.cmd_data;
                r_idx  <= '0;
                r_err  <= (w_cmd_op == OP_RSVD);
            end else if (r_state == S_RUN) begin
                r_idx  <= r_idx + ((r_op == OP_SUM) ? CW'(2) : CW'(1));
            end
        end
    end

    seq_accum #(.DW(DW)) u_accum (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_accept),
        .i_add  (w_add),
        .i_a    (mem.mem_rdata1),
        .i_b    (mem.mem_rdata2),
        .i_b_en (w_b_en),
        .o_sum  (w_sum),
        .o_ovf  (w_ovf)
    );

    assign cmd.result = w_sum;
    assign cmd.ovf    = w_ovf;
    assign cmd.err    = r_err;
endmodule

// File: tb/tb_mem_op_sequencer.sv
// Bench: sequencer plus register-file memory; directed plan steps then random commands against a reference model.
module tb_mem_op_sequencer;
    import mem_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_cmd_if  cif ();
    mem_port_if mif ();

    mem_op_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (cif.slave),
        .mem   (mif.master)
    );

    logic [7:0] mem [16];
    logic       pl_en;
    logic [3:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (mif.mem_we)
            mem[mif.mem_waddr] <= mif.mem_wdata;
    end
    assign mif.mem_rdata1 = mem[mif.mem_raddr1];
    assign mif.mem_rdata2 = mem[mif.mem_raddr2];

    logic [7:0] mref [16];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: value i+1, mode 1: constant v, mode 2: random
    task automatic preload(input int mode, input logic [7:0] v);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = 4'(i);
            pl_data = (mode == 0) ? 8'(i + 1) : (mode == 1) ? v : 8'($urandom);
            mref[i] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic cmp_mem(input string tag);
        int nmis = 0;
        for (int i = 0; i < 16; i++)
            if (mem[i] !== mref[i]) nmis++;
        check(tag, nmis, 0);
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                        input logic [4:0] cnt, input logic [7:0] data, input bit hold);
        int waits = 0;
        @(negedge clk);
        check("idle_done_low", cif.done, 0);
        check("idle_busy_low", cif.busy, 0);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_src   = src;
        cif.cmd_dst   = dst;
        cif.cmd_count = cnt;
        cif.cmd_data  = data;
        while (!cif.cmd_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check("accept_wait", waits, 0);
        @(posedge clk);
        #1;
        if (!hold) cif.cmd_valid = 1'b0;
    endtask

    task automatic finish(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                          input logic [4:0] cnt, input logic [7:0] data);
        int run, exp_w, s, k, nw, res;
        bit busy_ok, hold_ok;
        s = 0;
        for (int i = 0; i < int'(cnt); i++) begin
            case (op)
                2'b00: mref[(int'(dst) + i) % 16] = data;
                2'b01: mref[(int'(dst) + i) % 16] = mref[(int'(src) + i) % 16];
                2'b10: s += int'(mref[(int'(src) + i) % 16]);
                default: ;
            endcase
        end
        if (op == 2'b11 || cnt == 0) run = 0;
        else if (op == 2'b10)        run = (int'(cnt) + 1) / 2;
        else                         run = int'(cnt);
        exp_w = (op == 2'b00 || op == 2'b01) ? int'(cnt) : 0;
`ifdef MEMSEQ_SUM_SAT_EN
        res = (s > 255) ? 255 : s;
`else
        res = s % 256;
`endif
        k = 0; nw = 0; busy_ok = 1; hold_ok = 1;
        do begin
            @(negedge clk);
            k++;
            if (!cif.done) begin
                if (mif.mem_we) nw++;
                if (!cif.busy || cif.cmd_ready) busy_ok = 0;
            end
        end while (!cif.done && k < 60);
        check("done_latency", k, run + 1);
        check("write_count", nw, exp_w);
        check("busy_not_ready", busy_ok, 1);
        check("done_busy", cif.busy, 1);
        check("done_we_low", mif.mem_we, 0);
        check("result", cif.result, (op == 2'b10) ? res : 0);
        check("ovf", cif.ovf, (op == 2'b10 && s > 255) ? 1 : 0);
        check("err", cif.err, (op == 2'b11) ? 1 : 0);
        cmp_mem("mem_contents");
    endtask

    initial begin
        bit no_done;
        logic [1:0] rop;
        logic [3:0] rsrc, rdst;
        logic [4:0] rcnt;
        logic [7:0] rdat;

        reset = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        cif.cmd_valid = 1'b0; cif.cmd_op = '0; cif.cmd_src = '0;
        cif.cmd_dst = '0; cif.cmd_count = '0; cif.cmd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", cif.cmd_ready, 1);
        check("rst_busy", cif.busy, 0);
        check("rst_done", cif.done, 0);
        check("rst_err", cif.err, 0);
        check("rst_ovf", cif.ovf, 0);
        check("rst_result", cif.result, 0);
        check("rst_we", mif.mem_we, 0);
        check("rst_addrs", {mif.mem_waddr, mif.mem_raddr1, mif.mem_raddr2, mif.mem_wdata}, 0);
        reset = 1'b0;

        // FILL wrapping across the top of memory
        preload(2, 8'h00);
        send(2'b00, 4'd0, 4'd14, 5'd4, 8'hA5, 0);
        finish(2'b00, 4'd0, 4'd14, 5'd4, 8'hA5);

        preload(0, 8'h00);
        send(2'b01, 4'd0, 4'd8, 5'd8, 8'h00, 0);
        finish(2'b01, 4'd0, 4'd8, 5'd8, 8'h00);

        preload(0, 8'h00);
        send(2'b10, 4'd0, 4'd0, 5'd5, 8'h00, 0);
        finish(2'b10, 4'd0, 4'd0, 5'd5, 8'h00);

        preload(1, 8'h20);
        send(2'b10, 4'd3, 4'd0, 5'd16, 8'h00, 0);
        finish(2'b10, 4'd3, 4'd0, 5'd16, 8'h00);

        send(2'b00, 4'd0, 4'd4, 5'd0, 8'h5A, 0);
        finish(2'b00, 4'd0, 4'd4, 5'd0, 8'h5A);
        send(2'b11, 4'd2, 4'd6, 5'd7, 8'h11, 0);
        finish(2'b11, 4'd2, 4'd6, 5'd7, 8'h11);

        // Reset during the third RUN cycle of an 8-element FILL
        preload(2, 8'h00);
        send(2'b00, 4'd0, 4'd5, 5'd8, 8'h3C, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", cif.busy, 0);
        check("rst_mid_ready", cif.cmd_ready, 1);
        no_done = 1;
        for (int i = 0; i < 5; i++) begin
            if (cif.done) no_done = 0;
            @(negedge clk);
        end
        check("rst_mid_no_done", no_done, 1);
        mref[5] = 8'h3C;
        mref[6] = 8'h3C;
        cmp_mem("rst_mid_mem");

        // cmd_valid held through a busy command with different fields
        preload(0, 8'h00);
        send(2'b01, 4'd0, 4'd8, 5'd4, 8'h00, 1);
        cif.cmd_op = 2'b00; cif.cmd_dst = 4'd2; cif.cmd_count = 5'd3; cif.cmd_data = 8'h77;
        finish(2'b01, 4'd0, 4'd8, 5'd4, 8'h00);
        send(2'b00, 4'd0, 4'd2, 5'd3, 8'h77, 0);
        finish(2'b00, 4'd0, 4'd2, 5'd3, 8'h77);

        // Overlapping COPY with dst ahead of src smears the leading element
        preload(0, 8'h00);
        send(2'b01, 4'd3, 4'd4, 5'd5, 8'h00, 0);
        finish(2'b01, 4'd3, 4'd4, 5'd5, 8'h00);

        for (int n = 0; n < 24; n++) begin
            if (n % 8 == 0) preload(2, 8'h00);
            rop  = 2'($urandom_range(0, 3));
            rsrc = 4'($urandom);
            rdst = 4'($urandom);
            rcnt = 5'($urandom_range(0, 16));
            rdat = 8'($urandom);
            send(rop, rsrc, rdst, rcnt, rdat, 0);
            finish(rop, rsrc, rdst, rcnt, rdat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
